lsu_mem: RTL and testbench

Load/store initiator between the MemoryAccess stage and the 32-bit byte-write-enable data RAM (1-cycle registered read, read-first). Accepts one RV32 load/store per request and generates the word address, per-byte write enables and lane-shifted write data. Aligns and sign/zero-extends read data and returns a single-cycle response. Accesses that straddle a word boundary are split into two RAM cycles.

---
 rtl/lsu_mem_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu_mem.sv | 186 ++++++++++++++++++
 tb/tb_lsu_mem.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_pkg.sv
// lsu_mem_pkg: shared constants, FSM encoding and small helpers for the
// load/store initiator (lsu_mem) and its alignment datapath (lsu_align).
package lsu_mem_pkg;

    localparam int LSU_AWIDTH = 12;
    localparam int LSU_DWIDTH = 32;

    // RV32 funct3 encodings for loads (stores reuse B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_SPLIT = 2'd2,
        ST_WAIT2 = 2'd3
    } lsu_state_t;

    // Byte-lane mask for an access size taken from funct3[1:0]
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Encodings that are not a legal RV32 load/store
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
        return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic. Produces the byte-enable pair
// and shifted store data for the request, and shifts/extends read data for
// the response. The upper store word only exists when MISALIGN_SPLIT_EN is
// defined, since only then can an access reach into the next RAM word.
module lsu_align
    import lsu_mem_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_off,
    input  logic [31:0] wr_data,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wd_lo,
`ifdef MISALIGN_SPLIT_EN
    output logic [31:0] wd_hi,
`endif
    input  logic [2:0]  rd_funct3,
    input  logic [1:0]  rd_off,
    input  logic [63:0] rd_data,
    output logic [31:0] rd_result
);

    logic [7:0]  be_pair;
    logic [31:0] rd_shift;

    // Store side: shift the size mask and the data into their byte lanes
    always_comb begin
        be_pair = {4'b0000, size_mask(wr_size)} << wr_off;
        be_lo   = be_pair[3:0];
        be_hi   = be_pair[7:4];
`ifdef MISALIGN_SPLIT_EN
        {wd_hi, wd_lo} = {32'h0, wr_data} << {wr_off, 3'b000};
`else
        wd_lo = wr_data << {wr_off, 3'b000};
`endif
    end

    // Load side: bring the addressed byte down to lane 0, then extend
    always_comb begin
        rd_shift = 32'(rd_data >> {rd_off, 3'b000});
        case (rd_funct3)
            F3_B:    rd_result = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_H:    rd_result = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_BU:   rd_result = {24'h0, rd_shift[7:0]};
            F3_HU:   rd_result = {16'h0, rd_shift[15:0]};
            default: rd_result = rd_shift;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// lsu_mem: load/store initiator in front of a 32-bit byte-enable RAM with a
// 1-cycle registered read. Optional feature macro: MISALIGN_SPLIT_EN, which
// splits word-straddling accesses into two RAM cycles (SPLIT/WAIT2); without
// it, naturally misaligned accesses return an error.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE out of reset.
// rsp_valid is a one-cycle pulse per transferred request and has no ready.
module lsu_mem
    import lsu_mem_pkg::*;
#(
    parameter int AWIDTH = LSU_AWIDTH,
    parameter int DWIDTH = LSU_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [AWIDTH+1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [3:0]        ram_we,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata
);

    lsu_state_t        state_q, state_d;
    logic              xfer, req_err, span;
    logic [1:0]        off;
    logic [AWIDTH-1:0] word;
    logic [3:0]        be_lo, be_hi;
    logic [31:0]       wd_lo;
    logic [63:0]       rd_data;
    logic [31:0]       rd_result;

    logic              we_q, err_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [AWIDTH-1:0] addr_q, addr_c;
    logic [31:0]       wdata_q, wdata_c;
    logic [3:0]        we_c;
`ifdef MISALIGN_SPLIT_EN
    logic [31:0]       wd_hi, wd_hi_q, lo_hold;
    logic [3:0]        be_hi_q;
    logic [AWIDTH-1:0] word_q;
`endif

    assign off       = req_addr[1:0];
    assign word      = req_addr[AWIDTH+1:2];
    assign req_ready = rst_n && (state_q == ST_IDLE);
    assign xfer      = req_valid && req_ready;
    assign span      = |be_hi;

`ifdef MISALIGN_SPLIT_EN
    assign req_err = f3_illegal(req_we, req_funct3);
    assign rd_data = (state_q == ST_WAIT2) ? {ram_rdata, lo_hold} : {32'h0, ram_rdata};
`else
    // Anything crossing a word, plus a halfword on an odd byte, is misaligned
    assign req_err = f3_illegal(req_we, req_funct3) || span ||
                     ((req_funct3[1:0] == 2'b01) && off[0]);
    assign rd_data = {32'h0, ram_rdata};
`endif

    lsu_align u_align (
        .wr_size   (req_funct3[1:0]),
        .wr_off    (off),
        .wr_data   (req_wdata),
        .be_lo     (be_lo),
        .be_hi     (be_hi),
        .wd_lo     (wd_lo),
`ifdef MISALIGN_SPLIT_EN
        .wd_hi     (wd_hi),
`endif
        .rd_funct3 (f3_q),
        .rd_off    (off_q),
        .rd_data   (rd_data),
        .rd_result (rd_result)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: a clean spanning request takes the two-access path
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
`ifdef MISALIGN_SPLIT_EN
                    state_d = (span && !req_err) ? ST_SPLIT : ST_WAIT1;
`else
                    state_d = ST_WAIT1;
`endif
                end
            end
            ST_WAIT1: state_d = ST_IDLE;
            ST_SPLIT: state_d = ST_WAIT2;
            ST_WAIT2: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // RAM drive: issue in IDLE (and SPLIT), otherwise hold address and data
    always_comb begin
        addr_c  = addr_q;
        wdata_c = wdata_q;
        we_c    = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (xfer && !req_err) begin
                    addr_c  = word;
                    wdata_c = wd_lo;
                    if (req_we) we_c = be_lo;
                end
            end
`ifdef MISALIGN_SPLIT_EN
            ST_SPLIT: begin
                addr_c  = word_q + 1'b1;
                wdata_c = wd_hi_q;
                if (we_q) we_c = be_hi_q;
            end
`endif
            default: ;
        endcase
    end

    assign ram_addr  = addr_c;
    assign ram_wdata = wdata_c;
    assign ram_we    = rst_n ? we_c : 4'b0000;

    // Request latches, RAM hold registers and the registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
`ifdef MISALIGN_SPLIT_EN
            word_q    <= '0;
            wd_hi_q   <= '0;
            be_hi_q   <= 4'b0000;
            lo_hold   <= '0;
`endif
        end else begin
            addr_q    <= addr_c;
            wdata_q   <= wdata_c;
            rsp_valid <= 1'b0;
            if (xfer) begin
                we_q  <= req_we;
                err_q <= req_err;
                f3_q  <= req_funct3;
                off_q <= off;
`ifdef MISALIGN_SPLIT_EN
                word_q  <= word;
                wd_hi_q <= wd_hi;
                be_hi_q <= be_hi;
`endif
            end
            case (state_q)
                ST_WAIT1, ST_WAIT2: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_rdata <= (err_q || we_q) ? '0 : rd_result;
                end
`ifdef MISALIGN_SPLIT_EN
                ST_SPLIT: lo_hold <= ram_rdata;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: directed bench for lsu_mem with a behavioural RAM, an expected
// response queue and a monitor that checks response data, error and cycle.
module tb_lsu_mem;
    import lsu_mem_pkg::*;

    localparam int AW = 12;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata, ram_rdata;

    logic [31:0]   ram_mem [0:(1<<AW)-1];
    logic [64:0]   exp_q[$];   // {err, rdata, response cycle}
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem #(.AWIDTH(AW), .DWIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // RAM model: registered read-first, byte write enables
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = 32'h0;
        ram_mem[0]           = 32'h11223344;
        ram_mem[(1 << AW)-1] = 32'hAABBCCDD;
        ram_rdata = 32'h0;
        forever begin
            @(posedge clk);
            ram_rdata <= ram_mem[ram_addr];
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) ram_mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every response must match the head of the expected queue
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d expected none", cyc);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e[64]});
                chk("rsp_rdata", rsp_rdata, e[63:32]);
                chk("rsp_cycle", cyc, e[31:0]);
            end
        end
    end

    // driver: present one request, check the issuing RAM cycle(s), queue the response
    task automatic issue(input logic we, input logic [2:0] f3, input logic [AW+1:0] addr,
                         input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                         input int lat, input logic [3:0] exp_we0, input logic [31:0] exp_wd0,
                         input logic [3:0] exp_we1, input logic [AW-1:0] exp_a1);
        int guard;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got req_ready=0 expected 1 within 20 cycles");
            req_valid = 1'b0;
            return;
        end
        chk("ram_we0", {28'h0, ram_we}, {28'h0, exp_we0});
        if (!exp_err) chk("ram_addr0", {20'h0, ram_addr}, {20'h0, addr[AW+1:2]});
        if (we && !exp_err) chk("ram_wdata0", ram_wdata, exp_wd0);
        exp_q.push_back({exp_err, exp_rd, 32'(cyc + lat)});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (lat == 3) begin
            @(negedge clk);
            chk("ram_addr1", {20'h0, ram_addr}, {20'h0, exp_a1});
            chk("ram_we1", {28'h0, ram_we}, {28'h0, exp_we1});
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    localparam logic [AW+1:0] ABORT_ADDR = SPLIT ? 14'h042 : 14'h040;
    localparam logic [3:0]    ABORT_WE0  = SPLIT ? 4'b1100 : 4'b1111;
    localparam logic [31:0]   ABORT_LO   = SPLIT ? 32'hF00D0000 : 32'hCAFEF00D;

    initial begin
        // reset with a request pending
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 14'h010;
        req_wdata  = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_ram_we", {28'h0, ram_we}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_req_ready", {31'h0, req_ready}, 32'h1);

        // aligned stores and loads with extension
        issue(1'b1, F3_W,  14'h010, 32'hDEADBEEF, 1'b0, 32'h0,        2, 4'b1111, 32'hDEADBEEF, 4'h0, '0);
        issue(1'b0, F3_B,  14'h013, 32'h0,        1'b0, 32'hFFFFFFDE, 2, 4'b0000, 32'h0,        4'h0, '0);
        issue(1'b0, F3_BU, 14'h013, 32'h0,        1'b0, 32'h000000DE, 2, 4'b0000, 32'h0,        4'h0, '0);
        issue(1'b1, F3_H,  14'h012, 32'h00008001, 1'b0, 32'h0,        2, 4'b1100, 32'h80010000, 4'h0, '0);
        issue(1'b0, F3_H,  14'h012, 32'h0,        1'b0, 32'hFFFF8001, 2, 4'b0000, 32'h0,        4'h0, '0);
        issue(1'b0, F3_HU, 14'h012, 32'h0,        1'b0, 32'h00008001, 2, 4'b0000, 32'h0,        4'h0, '0);
        issue(1'b1, F3_B,  14'h017, 32'h1234565A, 1'b0, 32'h0,        2, 4'b1000, 32'h5A000000, 4'h0, '0);
        issue(1'b0, F3_B,  14'h017, 32'h0,        1'b0, 32'h0000005A, 2, 4'b0000, 32'h0,        4'h0, '0);
        issue(1'b0, F3_W,  14'h010, 32'h0,        1'b0, 32'h8001BEEF, 2, 4'b0000, 32'h0,        4'h0, '0);

        // misalignment: inside a word, across words, and across the top of memory
        issue(1'b0, F3_H, 14'h011, 32'h0, !SPLIT, SPLIT ? 32'h000001BE : 32'h0, 2,
              4'b0000, 32'h0, 4'h0, '0);
        issue(1'b1, F3_W, 14'h021, 32'h11223344, !SPLIT, 32'h0, SPLIT ? 3 : 2,
              SPLIT ? 4'b1110 : 4'b0000, 32'h22334400, 4'b0001, 12'd9);
        issue(1'b0, F3_W, 14'h021, 32'h0, !SPLIT, SPLIT ? 32'h11223344 : 32'h0, SPLIT ? 3 : 2,
              4'b0000, 32'h0, 4'b0000, 12'd9);
        issue(1'b0, F3_W, 14'h3FFE, 32'h0, !SPLIT, SPLIT ? 32'h3344AABB : 32'h0, SPLIT ? 3 : 2,
              4'b0000, 32'h0, 4'b0000, 12'd0);

        // illegal funct3 on a load and on a store
        issue(1'b0, 3'b011, 14'h010, 32'h0,        1'b1, 32'h0,        2, 4'b0000, 32'h0, 4'h0, '0);
        issue(1'b1, 3'b100, 14'h010, 32'hFFFFFFFF, 1'b1, 32'h0,        2, 4'b0000, 32'h0, 4'h0, '0);
        issue(1'b0, F3_W,   14'h010, 32'h0,        1'b0, 32'h8001BEEF, 2, 4'b0000, 32'h0, 4'h0, '0);
        drain();

        chk("mem_word4", ram_mem[4], 32'h8001BEEF);
        chk("mem_word5", ram_mem[5], 32'h5A000000);
        chk("mem_word8", ram_mem[8], SPLIT ? 32'h22334400 : 32'h0);
        chk("mem_word9", ram_mem[9], SPLIT ? 32'h00000011 : 32'h0);

        // reset while a store is still in flight: no response may appear
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = ABORT_ADDR;
        req_wdata  = 32'hCAFEF00D;
        #1;
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_we0", {28'h0, ram_we}, {28'h0, ABORT_WE0});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("abort_we1", {28'h0, ram_we}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
        chk("abort_mem_lo", ram_mem[16], ABORT_LO);
        chk("abort_mem_hi", ram_mem[17], 32'h0);
        issue(1'b0, F3_W, 14'h040, 32'h0, 1'b0, ABORT_LO, 2, 4'b0000, 32'h0, 4'h0, '0);
        issue(1'b0, F3_W, 14'h044, 32'h0, 1'b0, 32'h0,    2, 4'b0000, 32'h0, 4'h0, '0);
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
